// File: rtl/xcorr_pkg.sv
// Shared types for the cross-correlation peak/lock block: FSM states, lag index,
// the debug view of the lock FSM and the score-width helper.
package xcorr_pkg;

  localparam int NLAGS = 4;

  typedef logic [$clog2(NLAGS)-1:0] lag_t;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } lockState_t;

  typedef struct packed {
    lockState_t state;
    lag_t       cand;
  } lockDbg_t;

  // Scores run 0..nData inclusive, so one bit more than log2 of the window.
  function automatic int scoreWidth(input int nData);
    return $clog2(nData) + 1;
  endfunction

endpackage

// File: rtl/xcorr_max4.sv
// Combinational argmax over the four lag scores; on equal scores the lower
// lag index wins.
module xcorr_max4
  import xcorr_pkg::*;
#(
  parameter int SW = scoreWidth(128)
) (
  input  logic [SW-1:0] scoreA,
  input  logic [SW-1:0] scoreB,
  input  logic [SW-1:0] scoreC,
  input  logic [SW-1:0] scoreD,
  output lag_t          maxLag,
  output logic [SW-1:0] maxScore
);

  lag_t          abLag;
  lag_t          cdLag;
  logic [SW-1:0] abScore;
  logic [SW-1:0] cdScore;

  // Strict greater-than at every level keeps the lower index on ties.
  always_comb begin
    abLag   = 2'd0;
    abScore = scoreA;
    if (scoreB > scoreA) begin
      abLag   = 2'd1;
      abScore = scoreB;
    end
    cdLag   = 2'd2;
    cdScore = scoreC;
    if (scoreD > scoreC) begin
      cdLag   = 2'd3;
      cdScore = scoreD;
    end
    maxLag   = abLag;
    maxScore = abScore;
    if (cdScore > abScore) begin
      maxLag   = cdLag;
      maxScore = cdScore;
    end
  end

endmodule

// File: rtl/xcorr_peak_lock.sv
// Per-frame peak lag selection with a SEARCH/CONFIRM/LOCKED hysteresis FSM.
// Stage 1 registers the scores, stage 2 picks the peak and steps the FSM.
module xcorr_peak_lock
  import xcorr_pkg::*;
#(
  parameter int NDATA     = 128,
  parameter int NDATA_LOG = $clog2(NDATA),
  parameter int LOCK_CNT  = 3,
  parameter int MISS_CNT  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din_valid,
  input  logic [NDATA_LOG:0]   dinA,
  input  logic [NDATA_LOG:0]   dinB,
  input  logic [NDATA_LOG:0]   dinC,
  input  logic [NDATA_LOG:0]   dinD,
  input  logic [NDATA_LOG:0]   threshold,
  output logic                 dout_valid,
  output lag_t                 dout_lag,
  output logic [NDATA_LOG:0]   dout_peak,
  output logic                 locked,
  output logic                 lock_lost,
  output lockDbg_t             dbg
);

  localparam int SW = NDATA_LOG + 1;
  localparam int HW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(MISS_CNT + 1);
  localparam logic [HW-1:0] LOCK_MAX = HW'(LOCK_CNT);
  localparam logic [MW-1:0] MISS_MAX = MW'(MISS_CNT);

  // Handshake: din_valid marks a score set for exactly one cycle with no
  // backpressure; dout_valid is the matching one-cycle strobe two edges later.

  logic          s1Valid;
  logic [SW-1:0] s1ScoreA;
  logic [SW-1:0] s1ScoreB;
  logic [SW-1:0] s1ScoreC;
  logic [SW-1:0] s1ScoreD;
  logic [SW-1:0] s1Thr;

  lag_t          maxLag;
  logic [SW-1:0] maxScore;
  logic          qual;

  lockState_t    state;
  lockState_t    stateNext;
  lag_t          cand;
  lag_t          candNext;
  logic [HW-1:0] hitCnt;
  logic [HW-1:0] hitNext;
  logic [HW-1:0] hitInc;
  logic [MW-1:0] missCnt;
  logic [MW-1:0] missNext;
  logic [MW-1:0] missInc;
  logic          lostNext;

  xcorr_max4 #(.SW(SW)) u_max4 (
    .scoreA  (s1ScoreA),
    .scoreB  (s1ScoreB),
    .scoreC  (s1ScoreC),
    .scoreD  (s1ScoreD),
    .maxLag  (maxLag),
    .maxScore(maxScore)
  );

  assign qual    = (maxScore >= s1Thr);
  assign hitInc  = (hitCnt == LOCK_MAX) ? hitCnt : hitCnt + HW'(1);
  assign missInc = (missCnt == MISS_MAX) ? missCnt : missCnt + MW'(1);

  always_comb begin
    stateNext = state;
    candNext  = cand;
    hitNext   = hitCnt;
    missNext  = missCnt;
    lostNext  = 1'b0;
    if (s1Valid) begin
      case (state)
        SEARCH: begin
          if (qual) begin
            candNext  = maxLag;
            hitNext   = HW'(1);
            missNext  = '0;
            stateNext = (LOCK_CNT == 1) ? LOCKED : CONFIRM;
          end
        end
        CONFIRM: begin
          if (qual && (maxLag == cand)) begin
            hitNext = hitInc;
            if (hitInc == LOCK_MAX) begin
              stateNext = LOCKED;
              missNext  = '0;
            end
          end else if (qual) begin
            candNext = maxLag;
            hitNext  = HW'(1);
          end else begin
            stateNext = SEARCH;
            hitNext   = '0;
          end
        end
        LOCKED: begin
          if (qual && (maxLag == cand)) begin
            missNext = '0;
          end else if (missInc == MISS_MAX) begin
            stateNext = SEARCH;
            lostNext  = 1'b1;
            hitNext   = '0;
            missNext  = '0;
          end else begin
            missNext = missInc;
          end
        end
        default: begin
          stateNext = SEARCH;
          hitNext   = '0;
          missNext  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid    <= 1'b0;
      s1ScoreA   <= '0;
      s1ScoreB   <= '0;
      s1ScoreC   <= '0;
      s1ScoreD   <= '0;
      s1Thr      <= '0;
      state      <= SEARCH;
      cand       <= '0;
      hitCnt     <= '0;
      missCnt    <= '0;
      dout_valid <= 1'b0;
      dout_lag   <= '0;
      dout_peak  <= '0;
      locked     <= 1'b0;
      lock_lost  <= 1'b0;
    end else begin
      s1Valid <= din_valid;
      if (din_valid) begin
        s1ScoreA <= dinA;
        s1ScoreB <= dinB;
        s1ScoreC <= dinC;
        s1ScoreD <= dinD;
        s1Thr    <= threshold;
      end
      state      <= stateNext;
      cand       <= candNext;
      hitCnt     <= hitNext;
      missCnt    <= missNext;
      dout_valid <= s1Valid;
      if (s1Valid) begin
        dout_lag  <= maxLag;
        dout_peak <= maxScore;
      end
      locked    <= (stateNext == LOCKED);
      lock_lost <= lostNext;
    end
  end

  assign dbg = '{state: state, cand: cand};

endmodule

// File: tb/tb_xcorr_peak_lock.sv
// Bench for xcorr_peak_lock: a reference model pushes expected results per frame
// and the per-cycle monitor pops and compares them when dout_valid fires.
module tb_xcorr_peak_lock;
  import xcorr_pkg::*;

  localparam int NDATA     = 128;
  localparam int NDATA_LOG = 7;
  localparam int SW        = NDATA_LOG + 1;
  localparam int LOCK_CNT  = 3;
  localparam int MISS_CNT  = 4;
  localparam int W         = 2 + SW + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          din_valid = 1'b0;
  logic [SW-1:0] dinA = '0;
  logic [SW-1:0] dinB = '0;
  logic [SW-1:0] dinC = '0;
  logic [SW-1:0] dinD = '0;
  logic [SW-1:0] threshold = '0;
  logic          dout_valid;
  lag_t          dout_lag;
  logic [SW-1:0] dout_peak;
  logic          locked;
  logic          lock_lost;
  lockDbg_t      dbg;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [1:0] dvPipe = 2'b00;
  bit monEn = 1'b0;
  int mState = 0;
  int mCand = 0;
  int mHit = 0;
  int mMiss = 0;

  always #5 clk = ~clk;

  xcorr_peak_lock #(
    .NDATA(NDATA), .NDATA_LOG(NDATA_LOG), .LOCK_CNT(LOCK_CNT), .MISS_CNT(MISS_CNT)
  ) dut (
    .clk(clk), .rst(rst), .din_valid(din_valid),
    .dinA(dinA), .dinB(dinB), .dinC(dinC), .dinD(dinD), .threshold(threshold),
    .dout_valid(dout_valid), .dout_lag(dout_lag), .dout_peak(dout_peak),
    .locked(locked), .lock_lost(lock_lost), .dbg(dbg)
  );

  // ---------------- clock/cycle with monitor ----------------
  task automatic cycle();
    logic [W-1:0] e;
    @(negedge clk);
    if (monEn) begin
      checks++;
      if (dout_valid !== dvPipe[1]) begin
        errors++;
        $display("FAIL dout_valid_timing: got %b want %b at %0t", dout_valid, dvPipe[1], $time);
      end
      if (dout_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: lag %0d peak %0d with empty queue at %0t", dout_lag, dout_peak, $time);
        end else begin
          e = exp_q.pop_front();
          if ({dout_lag, dout_peak, locked, lock_lost} !== e)
          begin
            errors++;
            $display("FAIL result: got lag=%0d peak=%0d locked=%b lost=%b want lag=%0d peak=%0d locked=%b lost=%b at %0t",
                     dout_lag, dout_peak, locked, lock_lost,
                     e[W-1 -: 2], e[SW+1:2], e[1], e[0], $time);
          end
        end
      end else begin
        checks++;
        if (lock_lost !== 1'b0) begin
          errors++;
          $display("FAIL lock_lost_idle: got %b want 0 at %0t", lock_lost, $time);
        end
      end
    end
    @(posedge clk);
    dvPipe = rst ? 2'b00 : {dvPipe[0], din_valid};
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic void modelReset();
    mState = 0; mCand = 0; mHit = 0; mMiss = 0;
  endfunction

  function automatic void modelFrame(input logic [SW-1:0] a, b, c, d, thr);
    logic [SW-1:0] s[4];
    logic [SW-1:0] pk;
    int lag;
    bit qual;
    bit lost = 1'b0;
    s[0] = a; s[1] = b; s[2] = c; s[3] = d;
    lag = 0;
    pk = s[0];
    for (int i = 1; i < 4; i++) if (s[i] > pk) begin pk = s[i]; lag = i; end
    qual = (pk >= thr);
    if (mState == 2) begin
      if (qual && lag == mCand) mMiss = 0;
      else begin
        mMiss++;
        if (mMiss >= MISS_CNT) begin mState = 0; lost = 1'b1; mMiss = 0; mHit = 0; end
      end
    end else if (qual && mState == 1 && lag == mCand) begin
      mHit++;
      if (mHit >= LOCK_CNT) begin mState = 2; mMiss = 0; end
    end else if (qual) begin
      mCand = lag; mHit = 1; mMiss = 0;
      mState = (LOCK_CNT == 1) ? 2 : 1;
    end else begin
      mState = 0; mHit = 0;
    end
    exp_q.push_back({2'(lag), pk, (mState == 2) ? 1'b1 : 1'b0, lost});
  endfunction

  // ---------------- driver tasks ----------------
  task automatic sendFrame(input int a, b, c, d, thr);
    din_valid = 1'b1;
    dinA = SW'(a); dinB = SW'(b); dinC = SW'(c); dinD = SW'(d); threshold = SW'(thr);
    modelFrame(dinA, dinB, dinC, dinD, threshold);
    cycle();
    din_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 20) begin cycle(); k++; end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    cycle();
    monEn = 1'b1;
    cycle();
    checks++;
    if ({dout_valid, dout_lag, dout_peak, locked, lock_lost} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b lag=%0d peak=%0d locked=%b lost=%b want all 0",
               dout_valid, dout_lag, dout_peak, locked, lock_lost);
    end
    checks++;
    if (dbg.state !== SEARCH) begin
      errors++;
      $display("FAIL reset_state: got %0d want %0d", dbg.state, SEARCH);
    end
    rst = 1'b0;
    modelReset();
    cycle();
  endtask

  task automatic test_basic_lock();
    repeat (3) sendFrame(20, 110, 30, 5, 100);
    drain();
    checks++;
    if (locked !== 1'b1 || dbg.state !== LOCKED) begin
      errors++;
      $display("FAIL basic_lock: got locked=%b state=%0d want 1/%0d", locked, dbg.state, LOCKED);
    end
  endtask

  task automatic test_tie();
    sendFrame(90, 120, 120, 120, 100);
    drain();
    checks++;
    if (dout_lag !== 2'd1 || dout_peak !== SW'(120)) begin
      errors++;
      $display("FAIL tie: got lag=%0d peak=%0d want 1/120", dout_lag, dout_peak);
    end
  endtask

  task automatic test_loss();
    repeat (3) sendFrame(50, 50, 50, 50, 100);
    sendFrame(10, 101, 20, 30, 100);
    repeat (3) sendFrame(50, 50, 50, 50, 100);
    drain();
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL loss_hold: got locked=%b want 1", locked);
    end
    sendFrame(50, 50, 50, 50, 100);
    drain();
    checks++;
    if (locked !== 1'b0 || lock_lost !== 1'b0 || dbg.state !== SEARCH) begin
      errors++;
      $display("FAIL loss_drop: got locked=%b lost=%b state=%0d want 0/0/%0d",
               locked, lock_lost, dbg.state, SEARCH);
    end
  endtask

  task automatic test_restart();
    sendFrame(10, 10, 110, 10, 100);
    sendFrame(10, 10, 110, 10, 100);
    sendFrame(10, 10, 10, 115, 100);
    sendFrame(10, 10, 10, 115, 100);
    drain();
    checks++;
    if (locked !== 1'b0 || dbg.cand !== 2'd3) begin
      errors++;
      $display("FAIL restart_pending: got locked=%b cand=%0d want 0/3", locked, dbg.cand);
    end
    sendFrame(10, 10, 10, 115, 100);
    drain();
    checks++;
    if (locked !== 1'b1 || dout_lag !== 2'd3) begin
      errors++;
      $display("FAIL restart_lock: got locked=%b lag=%0d want 1/3", locked, dout_lag);
    end
    repeat (4) sendFrame(50, 50, 50, 50, 100);
    drain();
  endtask

  task automatic test_gapped();
    repeat (3) begin
      sendFrame(100, 40, 40, 40, 100);
      repeat ($urandom_range(1, 3)) cycle();
    end
    drain();
    checks++;
    if (locked !== 1'b1 || dout_lag !== 2'd0 || dout_peak !== SW'(100)) begin
      errors++;
      $display("FAIL gapped_lock: got locked=%b lag=%0d peak=%0d want 1/0/100", locked, dout_lag, dout_peak);
    end
    repeat (4) begin
      sendFrame(5, 6, 7, 8, 9);
      repeat ($urandom_range(1, 3)) cycle();
    end
    drain();
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL gapped_drop: got locked=%b want 0", locked);
    end
  endtask

  task automatic test_reset_mid();
    repeat (2) sendFrame(0, 0, 128, 0, 128);
    drain();
    rst = 1'b1;
    cycle();
    checks++;
    if ({dout_valid, dout_lag, dout_peak, locked, lock_lost} !== '0 || dbg.state !== SEARCH) begin
      errors++;
      $display("FAIL reset_mid_outputs: got v=%b lag=%0d peak=%0d locked=%b state=%0d want all 0",
               dout_valid, dout_lag, dout_peak, locked, dbg.state);
    end
    rst = 1'b0;
    modelReset();
    repeat (2) sendFrame(0, 0, 128, 0, 128);
    drain();
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_nolock: got locked=%b want 0", locked);
    end
    sendFrame(0, 0, 128, 0, 128);
    drain();
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_lock: got locked=%b want 1", locked);
    end
  endtask

  task automatic test_reset_wins();
    rst = 1'b1;
    din_valid = 1'b1;
    dinA = SW'(120); dinB = '0; dinC = '0; dinD = '0; threshold = SW'(1);
    cycle();
    rst = 1'b0;
    din_valid = 1'b0;
    modelReset();
    repeat (3) cycle();
    checks++;
    if (locked !== 1'b0 || dout_peak !== '0) begin
      errors++;
      $display("FAIL reset_wins: got locked=%b peak=%0d want 0/0", locked, dout_peak);
    end
  endtask

  task automatic test_back_to_back();
    int fav;
    sendFrame(0, 0, 0, 0, 0);
    for (int i = 0; i < 80; i++) begin
      if (i % 12 == 0) fav = $urandom_range(0, 3);
      sendFrame((fav == 0) ? $urandom_range(80, 128) : $urandom_range(0, 90),
                (fav == 1) ? $urandom_range(80, 128) : $urandom_range(0, 90),
                (fav == 2) ? $urandom_range(80, 128) : $urandom_range(0, 90),
                (fav == 3) ? $urandom_range(80, 128) : $urandom_range(0, 90),
                $urandom_range(60, 110));
      if ($urandom_range(0, 9) < 3) repeat ($urandom_range(1, 2)) cycle();
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_basic_lock();
    test_tie();
    test_loss();
    test_restart();
    test_gapped();
    test_reset_mid();
    test_reset_wins();
    test_back_to_back();
    repeat (3) cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xcorr_peak_lock.md
Name: xcorr_peak_lock

Overview:
- Sits directly downstream of the four-lag cross-correlation array.
- Consumes the four match-count scores (lags 0..3) once per frame and selects the best lag and its score.
- Runs a lock FSM with acquisition and loss hysteresis, producing a registered lag and score plus lock status for the symbol/frame aligner.

Parameters:
- NDATA, 128, correlation window length in bits; scores range 0..NDATA.
- NDATA_LOG, $clog2(NDATA), score width is NDATA_LOG+1.
- LOCK_CNT, 3, consecutive qualifying frames on the same lag needed to lock (>=1).
- MISS_CNT, 4, consecutive non-qualifying frames in LOCKED before lock is dropped (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active high.
- din_valid  in  1  a new score set is present this cycle.
- dinA  in  NDATA_LOG+1  score for lag 0.
- dinB  in  NDATA_LOG+1  score for lag 1.
- dinC  in  NDATA_LOG+1  score for lag 2.
- dinD  in  NDATA_LOG+1  score for lag 3.
- threshold  in  NDATA_LOG+1  minimum qualifying score; sampled with the scores.
- dout_valid  out  1  one-cycle strobe marking a new result.
- dout_lag  out  2  lag index of the frame's peak.
- dout_peak  out  NDATA_LOG+1  peak score of the frame.
- locked  out  1  level; high while in LOCKED.
- lock_lost  out  1  one-cycle pulse on the LOCKED->SEARCH transition.

Behaviour:
- Reset (rst high at a clk edge): all outputs 0, FSM in SEARCH, all counters and the candidate lag cleared. Reset wins over din_valid in the same cycle and aborts any acquisition in progress.
- Stage 1 (edge after din_valid): register the four scores, threshold, and a valid bit.
- Stage 2 (next edge): compute the max and update the FSM.
  - dout_valid, dout_lag, dout_peak, locked and lock_lost update together, 2 cycles after din_valid.
  - Fully pipelined: din_valid may be asserted every cycle.
- Max selection is unsigned. On ties the lowest lag index wins (A over B over C over D).
- A frame qualifies when peak >= threshold (unsigned compare, full width). Score 0 with threshold 0 qualifies.
- Cycles without a valid stage-1 frame cause no FSM, counter or output change, except that dout_valid and lock_lost return to 0.
- SEARCH:
  - Qualifying frame: cand = lag, hit_cnt = 1. Go to LOCKED if LOCK_CNT == 1, else CONFIRM.
  - Non-qualifying frame: stay in SEARCH.
- CONFIRM:
  - Qualifying frame with lag == cand: hit_cnt++. When the count reaches LOCK_CNT, go to LOCKED and clear miss_cnt.
  - Qualifying frame with a different lag: restart with cand = lag, hit_cnt = 1, stay in CONFIRM.
  - Non-qualifying frame: go to SEARCH and clear hit_cnt.
- LOCKED:
  - locked = 1.
  - Qualifying frame with lag == cand: miss_cnt = 0.
  - Any other frame (below threshold, or qualifying on a different lag) counts as a miss: miss_cnt++.
  - When miss_cnt reaches MISS_CNT: go to SEARCH, locked = 0, lock_lost = 1 for exactly one cycle, counters cleared.
  - cand does not change while LOCKED.
- locked goes high on the same edge that dout_valid reports the LOCK_CNT-th qualifying frame.
- Counter widths are $clog2(LOCK_CNT+1) and $clog2(MISS_CNT+1). Counters saturate and never wrap.
- dout_lag and dout_peak always report the frame's raw peak, not cand, and hold their value between strobes.

Decomposition:
- Shared package xcorr_pkg holds:
  - FSM state enum (SEARCH, CONFIRM, LOCKED).
  - Lag index typedef (2 bits) and NLAGS = 4.
  - Score-width function of NDATA.
- One natural sub-module, xcorr_max4: a combinational 4-input argmax with lowest-index tie-break, returning lag and score. It is instantiated once in stage 2.

Test Plan:
- NDATA=128, thr=100, scores {A=20,B=110,C=30,D=5} for 3 consecutive cycles -> dout_lag=1, dout_peak=110 each frame; locked rises with the 3rd result (cycle 5 after the first din_valid).
- Tie: scores {A=90,B=120,C=120,D=120}, thr=100 -> dout_lag=1, dout_peak=120.
- Acquisition restart: qualifying frames on lags 2,2,3,3,3 -> locked asserts only on the 5th result.
- Loss: from lock on lag 1, 4 frames with all scores 50 -> locked drops and lock_lost pulses for one cycle on the 4th result. A single qualifying lag-1 frame among 3 misses resets the miss count, so lock is held.
- Gapped input: frames separated by idle cycles -> the same lock timing counted in frames; dout_valid is high only 2 cycles after each din_valid.
- rst asserted mid-CONFIRM (after 2 hits) -> all outputs 0 next edge; 2 further hits do not lock, a 3rd does.
